// File: rtl/axi_lite_regbank_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-Lite register bank: response codes, the
// write-join and read FSM state enums, and a helper that sizes the register
// index field.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Index field width; never narrower than one bit so a single-register
    // bank still has a well-formed decode.
    function automatic int idx_width(input int n_regs);
        return (n_regs > 1) ? $clog2(n_regs) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
// AXI-Lite channel bundle (AW, W, B, AR, R) without clock or reset.
//   master modport: drives addresses, write data, valids and B/R readies.
//   slave  modport: drives AW/W/AR readies, B/R valids, responses, read data.
// ---------------------------------------------------------------------------
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data,
               r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data,
               r_resp, r_valid
    );

endinterface

// File: rtl/axi_lite_regbank_wjoin.sv
// ---------------------------------------------------------------------------
// axi_lite_wjoin
// Joins the AW and W channels, which may arrive in either order, into a single
// commit strobe for the register array, then holds B valid until accepted.
// Ports:
//   clk, rst                         clock, async active-high reset
//   aw_addr_i/aw_valid_i/aw_ready_o  AW channel
//   w_data_i/w_strb_i/w_valid_i/w_ready_o  W channel
//   b_valid_o/b_ready_i              B handshake (response code lives in top)
//   commit_o                         high in the cycle whose edge commits
//   commit_idx_o/data_o/strb_o       register index, data and strobe to commit
// ---------------------------------------------------------------------------
module axi_lite_wjoin
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic                    commit_o,
    output logic [IDX_W-1:0]        commit_idx_o,
    output logic [DATA_WIDTH-1:0]   commit_data_o,
    output logic [DATA_WIDTH/8-1:0] commit_strb_o
);

    wr_state_t               state_q;
    logic                    aw_ready_q;
    logic                    w_ready_q;
    logic                    b_valid_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    unused_addr_bits;

    assign aw_hs = aw_valid_i && aw_ready_q;
    assign w_hs  = w_valid_i && w_ready_q;

    // A half already held counts as "present": commit once both halves are in.
    assign commit_o = (aw_hs || (state_q == W_HAVE_AW)) &&
                      (w_hs  || (state_q == W_HAVE_W));

    assign commit_idx_o  = (state_q == W_HAVE_AW) ? idx_q  : aw_addr_i[IDX_W+1:2];
    assign commit_data_o = (state_q == W_HAVE_W)  ? data_q : w_data_i;
    assign commit_strb_o = (state_q == W_HAVE_W)  ? strb_q : w_strb_i;

    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;

    // Window decode is done upstream; only the index field matters here.
    assign unused_addr_bits = ^{aw_addr_i[ADDR_WIDTH-1:IDX_W+2], aw_addr_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            strb_q     <= '0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (commit_o) begin
                        state_q    <= W_RESP;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                    end else if (aw_hs) begin
                        state_q    <= W_HAVE_AW;
                        idx_q      <= aw_addr_i[IDX_W+1:2];
                        aw_ready_q <= 1'b0;
                    end else if (w_hs) begin
                        state_q    <= W_HAVE_W;
                        data_q     <= w_data_i;
                        strb_q     <= w_strb_i;
                        w_ready_q  <= 1'b0;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        state_q   <= W_RESP;
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        state_q    <= W_RESP;
                        aw_ready_q <= 1'b0;
                        b_valid_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        state_q    <= W_IDLE;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        b_valid_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= W_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b1;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank
// AXI-Lite slave terminating a bridge port with N_REGS 32-bit registers.
// Writes apply byte strobes and raise a one-cycle wr_pulse_o for the register
// touched; out-of-range accesses get SLVERR and leave the bank untouched.
// Ports:
//   clk, rst     clock, async active-high reset
//   s_axil       AXI-Lite slave channel bundle
//   regs_o       register contents, register i at [i*32 +: 32]
//   wr_pulse_o   one-cycle pulse per register, the cycle after its commit
// Build option:
//   AXIL_REGBANK_RO_ID_EN  register 0 becomes a read-only ID_VALUE; writes to
//                          it return SLVERR and raise no pulse.
// ---------------------------------------------------------------------------
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    N_REGS     = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
    input  logic                         clk,
    input  logic                         rst,
    axi_lite_if.slave                    s_axil,
    output logic [N_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [N_REGS-1:0]            wr_pulse_o
);

    localparam int IDX_W = idx_width(N_REGS);
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [IDX_W:0] N_REGS_W = (IDX_W + 1)'(N_REGS);

    logic [DATA_WIDTH-1:0] regs_q [N_REGS];
    logic [N_REGS-1:0]     pulse_q;
    logic [1:0]            b_resp_q;

    logic                  commit;
    logic [IDX_W-1:0]      c_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [NB-1:0]         c_strb;
    logic                  wr_ok;

    rd_state_t             rd_state_q;
    logic                  ar_ready_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic [IDX_W-1:0]      ar_idx;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_cfg;

    axi_lite_wjoin #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_wjoin (
        .clk           (clk),
        .rst           (rst),
        .aw_addr_i     (s_axil.aw_addr),
        .aw_valid_i    (s_axil.aw_valid),
        .aw_ready_o    (s_axil.aw_ready),
        .w_data_i      (s_axil.w_data),
        .w_strb_i      (s_axil.w_strb),
        .w_valid_i     (s_axil.w_valid),
        .w_ready_o     (s_axil.w_ready),
        .b_valid_o     (s_axil.b_valid),
        .b_ready_i     (s_axil.b_ready),
        .commit_o      (commit),
        .commit_idx_o  (c_idx),
        .commit_data_o (c_data),
        .commit_strb_o (c_strb)
    );

`ifdef AXIL_REGBANK_RO_ID_EN
    assign wr_ok = commit && ({1'b0, c_idx} < N_REGS_W) && (c_idx != '0);
`else
    assign wr_ok = commit && ({1'b0, c_idx} < N_REGS_W);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
`ifdef AXIL_REGBANK_RO_ID_EN
            regs_q[0] <= ID_VALUE;
`endif
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_ok && (c_idx == IDX_W'(i)) && c_strb[k]) begin
                        regs_q[i][8*k +: 8] <= c_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Pulse fires on any in-range commit, including an all-zero strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q  <= '0;
            b_resp_q <= AXI_OKAY;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                pulse_q[i] <= wr_ok && (c_idx == IDX_W'(i));
            end
            if (commit) begin
                b_resp_q <= wr_ok ? AXI_OKAY : AXI_SLVERR;
            end
        end
    end

    assign s_axil.b_resp = b_resp_q;
    assign wr_pulse_o    = pulse_q;

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < N_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign ar_idx = s_axil.ar_addr[IDX_W+1:2];
    assign rd_ok  = ({1'b0, ar_idx} < N_REGS_W);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    // Read data is sampled at the AR edge, so a same-edge write commit is not
    // yet visible and the old value is returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= AXI_OKAY;
        end else if (rd_state_q == R_IDLE) begin
            if (s_axil.ar_valid && ar_ready_q) begin
                rd_state_q <= R_DATA;
                ar_ready_q <= 1'b0;
                r_valid_q  <= 1'b1;
                r_data_q   <= rd_ok ? rd_val : '0;
                r_resp_q   <= rd_ok ? AXI_OKAY : AXI_SLVERR;
            end
        end else begin
            if (s_axil.r_ready) begin
                rd_state_q <= R_IDLE;
                ar_ready_q <= 1'b1;
                r_valid_q  <= 1'b0;
            end
        end
    end

    assign s_axil.ar_ready = ar_ready_q;
    assign s_axil.r_valid  = r_valid_q;
    assign s_axil.r_data   = r_data_q;
    assign s_axil.r_resp   = r_resp_q;

    assign unused_cfg = ^{s_axil.ar_addr[ADDR_WIDTH-1:IDX_W+2], s_axil.ar_addr[1:0],
                          ID_VALUE, AXI_DECERR};

endmodule

// File: tb/tb_axi_lite_regbank.sv
module tb_axi_lite_regbank;

    localparam int          N   = 6;
    localparam logic [31:0] IDV = 32'hA11E_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    logic [N*32-1:0] regs_o;
    logic [N-1:0]    wr_pulse_o;

    axi_lite_regbank #(.N_REGS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axil     (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: an array of register words plus the expected pulse.
    logic [31:0] m_regs [N];
    logic [N-1:0] pulse_vec = '0;
    int pulse_cyc = -1;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'h7);
    endfunction

    function automatic bit m_wr_ok(input logic [31:0] a);
`ifdef AXIL_REGBANK_RO_ID_EN
        return (m_idx(a) < N) && (m_idx(a) != 0);
`else
        return m_idx(a) < N;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (m_idx(a) >= N) return 32'h0;
        return m_regs[m_idx(a)];
    endfunction

    function automatic logic [N*32-1:0] model_flat();
        logic [N*32-1:0] f;
        for (int i = 0; i < N; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 32'h0;
`ifdef AXIL_REGBANK_RO_ID_EN
        m_regs[0] = IDV;
`endif
        pulse_cyc = -1;
    endtask

    // Called just after the commit edge.
    task automatic model_commit(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [1:0] er);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        pulse_cyc = cyc;
        pulse_vec = '0;
        if (m_wr_ok(a)) begin
            m_regs[m_idx(a)] = (m_regs[m_idx(a)] & ~mask) | (d & mask);
            pulse_vec[m_idx(a)] = 1'b1;
            er = 2'b00;
        end else begin
            er = 2'b10;
        end
    endtask

    // Per-cycle compare of exported state against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                logic [N-1:0] ep;
                ep = (cyc == pulse_cyc) ? pulse_vec : '0;
                chk("regs_o", regs_o, model_flat());
                chk("wr_pulse_o", wr_pulse_o, ep);
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input int b_hold, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit hs_aw, hs_w;
        int n = 0;
        logic [1:0] er;
        bus.aw_addr = a;
        bus.w_data  = d;
        bus.w_strb  = s;
        bus.b_ready = 1'b0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            if (w_done && !aw_done) begin
                chk("wait_w_ready", bus.w_ready, 1'b0);
                chk("wait_aw_ready", bus.aw_ready, 1'b1);
            end
            bus.aw_valid = !aw_done && (n >= w_lead);
            bus.w_valid  = !w_done;
            hs_aw = bus.aw_valid && bus.aw_ready;
            hs_w  = bus.w_valid && bus.w_ready;
            @(posedge clk);
            aw_done |= hs_aw;
            w_done  |= hs_w;
            n++;
        end
        if (!(aw_done && w_done)) begin
            total++;
            bad++;
            $display("FAIL write_accept: timeout after %0d cycles, expected handshakes", n);
            resp = 2'bxx;
            return;
        end
        #1;
        model_commit(a, d, s, er);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        for (int i = 0; i <= b_hold; i++) begin
            chk("b_valid", bus.b_valid, 1'b1);
            chk("b_resp", bus.b_resp, er);
            chk("resp_aw_ready", bus.aw_ready, 1'b0);
            if (i < b_hold) @(negedge clk);
        end
        resp = bus.b_resp;
        bus.b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.b_ready = 1'b0;
        chk("b_valid_drop", bus.b_valid, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] ed;
        logic [1:0]  er;
        @(negedge clk);
        chk("ar_ready_idle", bus.ar_ready, 1'b1);
        bus.ar_addr  = a;
        bus.ar_valid = 1'b1;
        bus.r_ready  = 1'b0;
        ed = m_read(a);
        er = (m_idx(a) < N) ? 2'b00 : 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.ar_valid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            chk("r_valid", bus.r_valid, 1'b1);
            chk("r_data", bus.r_data, ed);
            chk("r_resp", bus.r_resp, er);
            chk("r_ar_ready", bus.ar_ready, 1'b0);
            if (i < hold) @(negedge clk);
        end
        data = bus.r_data;
        resp = bus.r_resp;
        bus.r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.r_ready = 1'b0;
        chk("r_valid_drop", bus.r_valid, 1'b0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] old_rd;
        logic [1:0]  er;

        rst = 1'b1;
        bus.aw_addr = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
        bus.ar_addr = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_aw_ready", bus.aw_ready, 1'b1);
        chk("rst_w_ready", bus.w_ready, 1'b1);
        chk("rst_ar_ready", bus.ar_ready, 1'b1);
        chk("rst_b_valid", bus.b_valid, 1'b0);
        chk("rst_r_valid", bus.r_valid, 1'b0);
        chk("rst_b_resp", bus.b_resp, 2'b00);
        chk("rst_r_resp", bus.r_resp, 2'b00);
        chk("rst_r_data", bus.r_data, 32'h0);
        chk("rst_pulse", wr_pulse_o, 6'b0);
        cmp_en = 1;

        // Same-cycle AW and W.
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, resp);
        chk("lit_w1_resp", resp, 2'b00);
        chk("lit_reg1", regs_o[63:32], 32'hDEADBEEF);

        // W leads AW by three cycles, partial strobe.
        axi_write(32'h08, 32'h11223344, 4'b0101, 3, 0, resp);
        chk("lit_reg2", regs_o[95:64], 32'h00220044);

        // Read with R back-pressure.
        axi_read(32'h04, 4, rd, resp);
        chk("lit_rd1", rd, 32'hDEADBEEF);

        // Out-of-range write/read, with B back-pressure.
        axi_write(32'h18, 32'hFFFFFFFF, 4'hF, 0, 2, resp);
        chk("lit_oor_bresp", resp, 2'b10);
        axi_read(32'h18, 0, rd, resp);
        chk("lit_oor_rdata", rd, 32'h0);
        chk("lit_oor_rresp", resp, 2'b10);
        axi_read(32'h1C, 1, rd, resp);

        // Write and read to the same register accepted in the same cycle.
        @(negedge clk);
        bus.aw_addr = 32'h0C; bus.w_data = 32'hCAFEF00D; bus.w_strb = 4'hF;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        bus.ar_addr = 32'h0C; bus.ar_valid = 1'b1;
        old_rd = m_read(32'h0C);
        @(posedge clk);
        #1;
        model_commit(32'h0C, 32'hCAFEF00D, 4'hF, er);
        @(negedge clk);
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
        chk("cc_b_valid", bus.b_valid, 1'b1);
        chk("cc_b_resp", bus.b_resp, er);
        chk("cc_r_valid", bus.r_valid, 1'b1);
        chk("cc_r_data", bus.r_data, old_rd);
        chk("lit_cc_old", bus.r_data, 32'h0);
        chk("lit_cc_pulse", wr_pulse_o, 6'b001000);
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;
        axi_read(32'h0C, 0, rd, resp);
        chk("lit_cc_new", rd, 32'hCAFEF00D);

        // Register 0.
        axi_write(32'h00, 32'h5555AAAA, 4'b1001, 0, 0, resp);
        axi_read(32'h00, 0, rd, resp);
`ifdef AXIL_REGBANK_RO_ID_EN
        chk("lit_id_rd", rd, 32'hA11E0001);
        chk("lit_id_rresp", resp, 2'b00);
`else
        chk("lit_reg0_rd", rd, 32'h550000AA);
`endif

        // Upper and low address bits are ignored.
        axi_write(32'hFFFF_FF17, 32'h0BADCAFE, 4'b1100, 1, 0, resp);
        axi_read(32'h14, 0, rd, resp);
        chk("lit_alias_rd", rd, 32'h0BAD0000);

        // Reset while an AW is being held.
        @(negedge clk);
        bus.aw_addr = 32'h0C; bus.aw_valid = 1'b1; bus.w_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        chk("held_aw_ready", bus.aw_ready, 1'b0);
        chk("held_w_ready", bus.w_ready, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_regs", regs_o, model_flat());
        chk("async_rst_aw_ready", bus.aw_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_b_valid", bus.b_valid, 1'b0);
        chk("post_rst_w_ready", bus.w_ready, 1'b1);
        axi_read(32'h04, 0, rd, resp);
        axi_write(32'h04, 32'h12345678, 4'hF, 0, 0, resp);
        axi_read(32'h04, 0, rd, resp);
        chk("lit_post_rst_rd", rd, 32'h12345678);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
